// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - load/store memory responder with configurable wait states
module wait_state_memory #(
   parameter int WORD_COUNT  = 64,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32,
   parameter int WORD_W      = 32,
   parameter int MEM_COUNT_W = 3,
   parameter int MEM_CODE_W  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      i_req_addr,
   input  logic [WORD_W-1:0]      i_req_wr_data,
   input  logic                   i_req_wr_en,
   input  logic [MEM_COUNT_W-1:0] i_req_count,
   output logic [WORD_W-1:0]      o_res_rd_data,
   output logic [MEM_CODE_W-1:0]  o_res_code
);

   localparam logic [MEM_CODE_W-1:0] CODE_IDLE  = MEM_CODE_W'(0);
   localparam logic [MEM_CODE_W-1:0] CODE_BUSY  = MEM_CODE_W'(1);
   localparam logic [MEM_CODE_W-1:0] CODE_DONE  = MEM_CODE_W'(2);
   localparam logic [MEM_CODE_W-1:0] CODE_FAULT = MEM_CODE_W'(3);

   localparam logic [MEM_COUNT_W-1:0] COUNT_NONE = MEM_COUNT_W'(0);
   localparam logic [MEM_COUNT_W-1:0] COUNT_BYTE = MEM_COUNT_W'(1);
   localparam logic [MEM_COUNT_W-1:0] COUNT_HALF = MEM_COUNT_W'(2);
   localparam logic [MEM_COUNT_W-1:0] COUNT_WORD = MEM_COUNT_W'(4);

   localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(WORD_COUNT);
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                 state;
   logic [3:0]             wait_cnt;
   logic [WORD_W-1:0]      mem [WORD_COUNT];

   logic [ADDR_W-1:0]      lat_addr;
   logic [WORD_W-1:0]      lat_wr_data;
   logic                   lat_wr_en;
   logic [MEM_COUNT_W-1:0] lat_count;

   logic [ADDR_W-1:0]      sel_addr;
   logic [WORD_W-1:0]      sel_wr_data;
   logic                   sel_wr_en;
   logic [MEM_COUNT_W-1:0] sel_count;
   logic [ADDR_W-3:0]      word_idx;
   logic [IDX_W-1:0]       mem_idx;
   logic [WORD_W-1:0]      cur_word;
   logic [WORD_W-1:0]      merged;
   logic [WORD_W-1:0]      load_word;
   logic                   fault;
   logic                   enter_resp;

   // Request under evaluation: live inputs when a zero-latency access resolves straight from IDLE, latched copy otherwise
   always_comb begin
      sel_addr    = lat_addr;
      sel_wr_data = lat_wr_data;
      sel_wr_en   = lat_wr_en;
      sel_count   = lat_count;
      if (state == S_IDLE) begin
         sel_addr    = i_req_addr;
         sel_wr_data = i_req_wr_data;
         sel_wr_en   = i_req_wr_en;
         sel_count   = i_req_count;
      end
   end

   // Fault detection plus little-endian lane merge for stores and lane extraction for loads
   always_comb begin
      word_idx  = sel_addr[ADDR_W-1:2];
      mem_idx   = word_idx[IDX_W-1:0];
      cur_word  = mem[mem_idx];
      merged    = cur_word;
      load_word = '0;
      fault     = 1'b0;
      case (sel_count)
         COUNT_BYTE: begin
            merged[{sel_addr[1:0], 3'b000} +: 8] = sel_wr_data[7:0];
            load_word[7:0] = cur_word[{sel_addr[1:0], 3'b000} +: 8];
         end
         COUNT_HALF: begin
            merged[{sel_addr[1], 4'b0000} +: 16] = sel_wr_data[15:0];
            load_word[15:0] = cur_word[{sel_addr[1], 4'b0000} +: 16];
            fault = sel_addr[0];
         end
         COUNT_WORD: begin
            merged    = sel_wr_data;
            load_word = cur_word;
            fault     = (sel_addr[1:0] != 2'b00);
         end
         default: fault = 1'b1;
      endcase
      if (word_idx >= WORD_LIMIT) begin
         fault = 1'b1;
      end
      enter_resp = ((state == S_IDLE) && (sel_count != COUNT_NONE) && (LATENCY == 0))
                || ((state == S_WAIT) && (wait_cnt == 4'd0));
   end

   // Access sequencer: latch request, count wait states, commit and respond for one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         wait_cnt      <= 4'd0;
         o_res_code    <= CODE_IDLE;
         o_res_rd_data <= '0;
         lat_addr      <= '0;
         lat_wr_data   <= '0;
         lat_wr_en     <= 1'b0;
         lat_count     <= COUNT_NONE;
         for (int i = 0; i < WORD_COUNT; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               o_res_code    <= CODE_IDLE;
               o_res_rd_data <= '0;
               if (i_req_count != COUNT_NONE) begin
                  lat_addr    <= i_req_addr;
                  lat_wr_data <= i_req_wr_data;
                  lat_wr_en   <= i_req_wr_en;
                  lat_count   <= i_req_count;
                  if (LATENCY > 0) begin
                     state      <= S_WAIT;
                     wait_cnt   <= CNT_LOAD;
                     o_res_code <= CODE_BUSY;
                  end
               end
            end
            S_WAIT: begin
               o_res_code <= CODE_BUSY;
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: begin
               state         <= S_IDLE;
               o_res_code    <= CODE_IDLE;
               o_res_rd_data <= '0;
            end
         endcase
         if (enter_resp) begin
            state <= S_RESP;
            if (fault) begin
               o_res_code    <= CODE_FAULT;
               o_res_rd_data <= '0;
            end else begin
               o_res_code    <= CODE_DONE;
               o_res_rd_data <= sel_wr_en ? '0 : load_word;
               if (sel_wr_en) begin
                  mem[mem_idx] <= merged;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wait_state_memory.sv
// tb/tb_wait_state_memory.sv - randomized self-checking bench for wait_state_memory
module tb_wait_state_memory;

   logic        clk = 1'b0;
   logic        rst2, rst0;
   logic [31:0] addr2, wd2, addr0, wd0;
   logic        we2, we0;
   logic [2:0]  cnt2, cnt0;
   logic [31:0] rd2, rd0;
   logic [1:0]  code2, code0;

   int n_checks = 0;
   int n_fail   = 0;

   // byte-addressed reference memories, one per instance (0: LATENCY=0, 1: LATENCY=2)
   logic [7:0] mem_b [2][256];

   always #5 clk = ~clk;

   wait_state_memory #(.WORD_COUNT(64), .LATENCY(2)) u_dut2 (
      .clk(clk), .reset(rst2), .i_req_addr(addr2), .i_req_wr_data(wd2),
      .i_req_wr_en(we2), .i_req_count(cnt2), .o_res_rd_data(rd2), .o_res_code(code2));

   wait_state_memory #(.WORD_COUNT(64), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(rst0), .i_req_addr(addr0), .i_req_wr_data(wd0),
      .i_req_wr_en(we0), .i_req_count(cnt0), .o_res_rd_data(rd0), .o_res_code(code0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int d, input logic [31:0] a, input logic [31:0] w,
                        input logic e, input logic [2:0] c);
      if (d == 1) begin
         addr2 = a; wd2 = w; we2 = e; cnt2 = c;
      end else begin
         addr0 = a; wd0 = w; we0 = e; cnt0 = c;
      end
   endtask

   function automatic logic [1:0] get_code(input int d);
      return (d == 1) ? code2 : code0;
   endfunction

   function automatic logic [31:0] get_rd(input int d);
      return (d == 1) ? rd2 : rd0;
   endfunction

   task automatic clear_model(input int d);
      for (int i = 0; i < 256; i++) mem_b[d][i] = 8'h00;
   endtask

   // Reference: an access is a run of cnt bytes starting at addr in a 256-byte little-endian store
   task automatic ref_access(input int d, input logic [31:0] a, input logic [31:0] w,
                             input logic e, input logic [2:0] c,
                             output logic [1:0] code, output logic [31:0] rd);
      int n;
      bit bad;
      n   = int'(c);
      rd  = 32'h0;
      bad = !(n == 1 || n == 2 || n == 4);
      if (!bad) bad = ((a % n) != 0) || ((a / 4) >= 64);
      if (bad) begin
         code = 2'd3;
      end else begin
         code = 2'd2;
         for (int b = 0; b < n; b++) begin
            if (e) mem_b[d][int'(a) + b] = w[8*b +: 8];
            else   rd = rd | (32'(mem_b[d][int'(a) + b]) << (8*b));
         end
      end
   endtask

   // One access: request is presented during an IDLE cycle and sampled at the next rising edge
   task automatic access(input int d, input logic [31:0] a, input logic [31:0] w,
                         input logic e, input logic [2:0] c, input bit scramble);
      logic [1:0]  ecode;
      logic [31:0] erd;
      int lat;
      lat = (d == 1) ? 2 : 0;
      drive(d, a, w, e, c);
      ref_access(d, a, w, e, c, ecode, erd);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check("busy_code", 32'(get_code(d)), 32'd1);
         check("busy_rd", get_rd(d), 32'h0);
         if (scramble) drive(d, $urandom, $urandom, 1'($urandom), 3'($urandom_range(1, 7)));
      end
      @(negedge clk);
      check("resp_code", 32'(get_code(d)), 32'(ecode));
      if (!(e && ecode == 2'd2)) check("resp_rd", get_rd(d), erd);
      drive(d, 32'h0, 32'h0, 1'b0, 3'd0);
      @(negedge clk);
      check("idle_code", 32'(get_code(d)), 32'd0);
      check("idle_rd", get_rd(d), 32'h0);
   endtask

   logic [2:0] cnt_tab [10] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};

   initial begin
      logic [1:0]  ecode;
      logic [31:0] erd;
      rst2 = 1'b1; rst0 = 1'b1;
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      clear_model(0); clear_model(1);
      repeat (3) @(negedge clk);
      check("reset_code2", 32'(code2), 32'd0);
      check("reset_rd2", rd2, 32'h0);
      check("reset_code0", 32'(code0), 32'd0);
      check("reset_rd0", rd0, 32'h0);
      rst2 = 1'b0; rst0 = 1'b0;
      @(negedge clk);

      // directed word/byte/half traffic
      access(1, 32'h8, 32'hDEADBEEF, 1, 3'd4, 0);
      access(1, 32'h8, 32'h0, 0, 3'd4, 0);
      access(1, 32'h9, 32'h11, 1, 3'd1, 1);
      access(1, 32'h8, 32'h0, 0, 3'd4, 1);
      access(1, 32'hA, 32'h0, 0, 3'd2, 1);
      access(1, 32'hB, 32'h0, 0, 3'd1, 1);
      // faults leave the array alone
      access(1, 32'h6, 32'h0, 0, 3'd4, 0);
      access(1, 32'h8, 32'h0, 0, 3'd3, 0);
      access(1, 32'h100, 32'h55AA55AA, 1, 3'd4, 0);
      access(1, 32'h3, 32'h77, 1, 3'd2, 0);
      access(1, 32'h8, 32'h0, 0, 3'd4, 0);
      access(1, 32'h0, 32'h0, 0, 3'd4, 0);

      // request held across three accesses: one response every LATENCY+2 cycles
      drive(1, 32'h8, 32'h0, 1'b0, 3'd4);
      for (int r = 0; r < 3; r++) begin
         ref_access(1, 32'h8, 32'h0, 1'b0, 3'd4, ecode, erd);
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_busy", 32'(code2), 32'd1);
         end
         @(negedge clk);
         check("hold_code", 32'(code2), 32'(ecode));
         check("hold_rd", rd2, erd);
         @(negedge clk);
         check("hold_idle", 32'(code2), 32'd0);
         check("hold_idle_rd", rd2, 32'h0);
      end
      drive(1, 0, 0, 0, 0);
      @(negedge clk);

      // reset in the second BUSY cycle aborts the store
      drive(1, 32'h4, 32'h12345678, 1'b1, 3'd4);
      @(negedge clk);
      check("abort_busy1", 32'(code2), 32'd1);
      @(negedge clk);
      check("abort_busy2", 32'(code2), 32'd1);
      rst2 = 1'b1;
      drive(1, 0, 0, 0, 0);
      clear_model(1);
      @(negedge clk);
      check("abort_idle", 32'(code2), 32'd0);
      check("abort_rd", rd2, 32'h0);
      rst2 = 1'b0;
      @(negedge clk);
      check("abort_nodone", 32'(code2), 32'd0);
      access(1, 32'h4, 32'h0, 0, 3'd4, 0);

      // randomized traffic, including out-of-range and misaligned requests
      for (int t = 0; t < 150; t++) begin
         access(1, 32'($urandom_range(0, 32'h10F)), $urandom, 1'($urandom),
                cnt_tab[$urandom_range(0, 9)], 1'($urandom));
      end

      // zero-latency instance: DONE at k+1, IDLE at k+2
      access(0, 32'h10, 32'hCAFEF00D, 1, 3'd4, 0);
      access(0, 32'h10, 32'h0, 0, 3'd4, 0);
      access(0, 32'h13, 32'h0, 0, 3'd1, 0);
      access(0, 32'h12, 32'hBEEF, 1, 3'd2, 0);
      access(0, 32'h10, 32'h0, 0, 3'd4, 0);
      access(0, 32'h11, 32'h0, 0, 3'd2, 0);
      for (int t = 0; t < 60; t++) begin
         access(0, 32'($urandom_range(0, 32'h10F)), $urandom, 1'($urandom),
                cnt_tab[$urandom_range(0, 9)], 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
